// File: rtl/prog_loader_pkg.sv
// Shared definitions for the byte-stream program loader: FSM encoding and frame field sizes.
package prog_loader_pkg;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_LEN0 = 3'd0,
    ST_LEN1 = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Inbound byte stream plus instruction-memory write port of the program loader.
interface prog_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// Collects little-endian bytes into 32-bit words and emits a one-cycle registered write strobe.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_last,
  output logic        o_we,
  output logic [31:0] o_wdata
);
  localparam int IDX_W = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  logic [IDX_W-1:0] r_idx;
  logic [23:0]      r_shift;
  logic             r_we;
  logic [31:0]      r_wdata;

  assign o_last  = i_valid && (r_idx == LAST_IDX);
  assign o_we    = r_we;
  assign o_wdata = r_wdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx   <= '0;
      r_shift <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (i_clear) begin
        r_idx   <= '0;
        r_shift <= '0;
      end else if (i_valid) begin
        // Bytes enter at the top so byte0 ends up in the least-significant lane.
        if (r_idx == LAST_IDX) begin
          r_wdata <= {i_byte, r_shift};
          r_we    <= 1'b1;
          r_idx   <= '0;
        end else begin
          r_shift <= {i_byte, r_shift[23:8]};
          r_idx   <= r_idx + IDX_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/prog_loader.sv
// Loads a framed, checksummed program image into instruction memory and holds the CPU in reset until done.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic            clk,
  input  logic            reset,
  prog_loader_if.slave    bus,
  input  logic            restart,
  output logic            cpu_reset_n,
  output logic            done,
  output logic            error
);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [16:0]       MAX_LEN = 17'(MAX_WORDS);

  state_t            r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_word_cnt;
  logic [7:0]        r_csum;
  logic              r_in_ready;
  logic              r_done;
  logic              r_error;
  logic              r_cpu_reset_n;
  logic [ADDR_W-1:0] r_imem_addr;

  logic              w_accept;
  logic [15:0]       w_len;
  logic              w_last_byte;
  logic              w_restart_go;
  logic [ADDR_W-1:0] w_word_addr;
  logic              w_we;
  logic [31:0]       w_wdata;

  assign w_accept     = bus.in_valid && r_in_ready;
  assign w_len        = {bus.in_data, r_len[7:0]};
  assign w_restart_go = restart && (r_state == ST_DONE || r_state == ST_ERR);
  assign w_word_addr  = BASE + {r_word_cnt[ADDR_W-3:0], 2'b00};

  word_assembler u_asm (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_restart_go),
    .i_valid (w_accept && (r_state == ST_DATA)),
    .i_byte  (bus.in_data),
    .o_last  (w_last_byte),
    .o_we    (w_we),
    .o_wdata (w_wdata)
  );

  assign bus.in_ready   = r_in_ready;
  assign bus.imem_we    = w_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = w_wdata;
  assign cpu_reset_n    = r_cpu_reset_n;
  assign done           = r_done;
  assign error          = r_error;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_LEN0;
      r_len         <= '0;
      r_word_cnt    <= '0;
      r_csum        <= '0;
      r_in_ready    <= 1'b1;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_cpu_reset_n <= 1'b0;
      r_imem_addr   <= BASE;
    end else begin
      case (r_state)
        ST_LEN0: if (w_accept) begin
          r_len[7:0] <= bus.in_data;
          r_csum     <= r_csum ^ bus.in_data;
          r_state    <= ST_LEN1;
        end
        ST_LEN1: if (w_accept) begin
          r_len[15:8] <= bus.in_data;
          r_csum      <= r_csum ^ bus.in_data;
          if ({1'b0, w_len} > MAX_LEN) begin
            r_state    <= ST_ERR;
            r_in_ready <= 1'b0;
            r_error    <= 1'b1;
          end else if (w_len == 16'd0) begin
            r_state <= ST_CSUM;
          end else begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: if (w_accept) begin
          r_csum <= r_csum ^ bus.in_data;
          // Address is latched alongside the word so it is valid in the strobe cycle.
          if (w_last_byte) begin
            r_imem_addr <= w_word_addr;
            r_word_cnt  <= r_word_cnt + 16'd1;
            if (r_word_cnt == r_len - 16'd1) r_state <= ST_CSUM;
          end
        end
        ST_CSUM: if (w_accept) begin
          r_in_ready <= 1'b0;
          if (bus.in_data == r_csum) begin
            r_state       <= ST_DONE;
            r_done        <= 1'b1;
            r_cpu_reset_n <= 1'b1;
          end else begin
            r_state <= ST_ERR;
            r_error <= 1'b1;
          end
        end
        ST_DONE, ST_ERR: if (restart) begin
          r_state       <= ST_LEN0;
          r_len         <= '0;
          r_word_cnt    <= '0;
          r_csum        <= '0;
          r_in_ready    <= 1'b1;
          r_done        <= 1'b0;
          r_error       <= 1'b0;
          r_cpu_reset_n <= 1'b0;
        end
        default: begin
          r_state    <= ST_LEN0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed, table-driven bench for prog_loader with hand-computed frames, checksums and write sequences.
module tb_prog_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic restart = 1'b0;
  logic cpu_reset_n, done, error;

  prog_loader_if #(.ADDR_W(10)) bus ();

  prog_loader #(.ADDR_W(10), .MAX_WORDS(256), .BASE_ADDR(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .restart     (restart),
    .cpu_reset_n (cpu_reset_n),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [9:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
      $display("  write addr=%h data=%h", bus.imem_addr, bus.imem_wdata);
    end
  end

  typedef struct packed {
    logic [0:11][7:0]  bytes;
    int                nbytes;
    bit                thr;
    int                nwr;
    logic [0:1][9:0]   addr;
    logic [0:1][31:0]  data;
    bit                exp_done;
    bit                exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    restart = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit thr);
    int n;
    if (thr) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data = 8'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got in_ready=%b expected 1 within 20 cycles", bus.in_ready);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
  endtask

  task automatic send_frame(input logic [0:11][7:0] b, input int first, input int n, input bit thr);
    for (int i = first; i < n; i++) send_byte(b[i], thr);
    idle();
  endtask

  logic [0:11][7:0] basic_f;
  logic [0:11][7:0] beef_f;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;

    basic_f = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73, 8'h00};
    beef_f  = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    // basic load
    vecs[0] = '{bytes: basic_f, nbytes: 11, thr: 1'b0, nwr: 2,
                addr: {10'h000, 10'h004}, data: {32'h00500093, 32'h00A00113},
                exp_done: 1'b1, exp_err: 1'b0};
    // bad checksum (0x73 ^ 0xFF)
    vecs[1] = vecs[0];
    vecs[1].bytes[10] = 8'h8C;
    vecs[1].exp_done = 1'b0;
    vecs[1].exp_err = 1'b1;
    // oversize length 0x0101
    vecs[2] = '{bytes: {8'h01, 8'h01, 80'h0}, nbytes: 2, thr: 1'b0, nwr: 0,
                addr: '0, data: '0, exp_done: 1'b0, exp_err: 1'b1};
    // empty image
    vecs[3] = '{bytes: {8'h00, 8'h00, 8'h00, 72'h0}, nbytes: 3, thr: 1'b0, nwr: 0,
                addr: '0, data: '0, exp_done: 1'b1, exp_err: 1'b0};
    // throttled basic load
    vecs[4] = vecs[0];
    vecs[4].thr = 1'b1;
    // single word
    vecs[5] = '{bytes: beef_f, nbytes: 7, thr: 1'b0, nwr: 1,
                addr: {10'h000, 10'h000}, data: {32'hDEADBEEF, 32'h0},
                exp_done: 1'b1, exp_err: 1'b0};

    for (int k = 0; k < 6; k++) begin
      do_reset();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_imem_we", 32'(bus.imem_we), 32'd0);
      chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
      chk("rst_imem_wdata", bus.imem_wdata, 32'd0);
      chk("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      wr_addr.delete();
      wr_data.delete();
      send_frame(vecs[k].bytes, 0, vecs[k].nbytes, vecs[k].thr);
      repeat (3) @(negedge clk);
      chk("vec_nwr", 32'(wr_addr.size()), 32'(vecs[k].nwr));
      for (int i = 0; i < vecs[k].nwr && i < wr_addr.size(); i++) begin
        chk("vec_addr", 32'(wr_addr[i]), 32'(vecs[k].addr[i]));
        chk("vec_data", wr_data[i], vecs[k].data[i]);
      end
      chk("vec_done", 32'(done), 32'(vecs[k].exp_done));
      chk("vec_error", 32'(error), 32'(vecs[k].exp_err));
      chk("vec_cpu_reset_n", 32'(cpu_reset_n), 32'(vecs[k].exp_done));
      chk("vec_in_ready", 32'(bus.in_ready), 32'd0);
      $display("vector %0d: writes=%0d done=%b error=%b cpu_reset_n=%b",
               k, wr_addr.size(), done, error, cpu_reset_n);
    end

    // Length boundary: N == MAX_WORDS proceeds, N == MAX_WORDS+1 errors one cycle after LEN_HI.
    do_reset();
    send_frame({8'h00, 8'h01, 80'h0}, 0, 2, 1'b0);
    chk("max_len_error", 32'(error), 32'd0);
    chk("max_len_in_ready", 32'(bus.in_ready), 32'd1);
    $display("boundary N=256: error=%b in_ready=%b", error, bus.in_ready);
    do_reset();
    wr_addr.delete();
    send_frame({8'h01, 8'h01, 80'h0}, 0, 2, 1'b0);
    chk("over_len_error_now", 32'(error), 32'd1);
    chk("over_len_in_ready_now", 32'(bus.in_ready), 32'd0);
    repeat (4) @(negedge clk);
    chk("over_len_no_write", 32'(wr_addr.size()), 32'd0);
    $display("boundary N=257: error=%b in_ready=%b writes=%0d", error, bus.in_ready, wr_addr.size());

    // Reset mid-DATA after 5 bytes, then a full load.
    do_reset();
    wr_addr.delete();
    wr_data.delete();
    send_frame(basic_f, 0, 5, 1'b0);
    do_reset();
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    chk("midrst_no_write", 32'(wr_addr.size()), 32'd0);
    send_frame(basic_f, 0, 11, 1'b0);
    repeat (2) @(negedge clk);
    chk("midrst_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("midrst_addr1", 32'(wr_addr[1]), 32'h004);
      chk("midrst_data0", wr_data[0], 32'h00500093);
      chk("midrst_data1", wr_data[1], 32'h00A00113);
    end
    chk("midrst_done", 32'(done), 32'd1);
    chk("midrst_cpu_reset_n_hi", 32'(cpu_reset_n), 32'd1);
    $display("reload after mid-frame reset: writes=%0d done=%b", wr_addr.size(), done);

    // Restart from DONE: cpu_reset_n falls on the restart edge, address/data hold.
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_in_ready", 32'(bus.in_ready), 32'd1);
    chk("restart_addr_hold", 32'(bus.imem_addr), 32'h004);
    chk("restart_wdata_hold", bus.imem_wdata, 32'h00A00113);
    @(negedge clk);
    restart = 1'b0;
    $display("restart: cpu_reset_n=%b in_ready=%b addr=%h", cpu_reset_n, bus.in_ready, bus.imem_addr);

    // Second load, with a stray restart pulse in LEN1 that must be ignored.
    wr_addr.delete();
    wr_data.delete();
    send_frame(beef_f, 0, 1, 1'b0);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    send_frame(beef_f, 1, 7, 1'b0);
    repeat (2) @(negedge clk);
    chk("second_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("second_addr", 32'(wr_addr[0]), 32'h000);
      chk("second_data", wr_data[0], 32'hDEADBEEF);
    end
    chk("second_done", 32'(done), 32'd1);
    chk("second_error", 32'(error), 32'd0);
    $display("second load: writes=%0d done=%b error=%b", wr_addr.size(), done, error);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader; the inbound counterpart of the end-of-run register-state dump. The dump reads state out of the CPU; this block writes a program into instruction memory before the CPU runs.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to the instruction-memory write port and holds the CPU in reset until a complete, checksum-verified image is loaded.
- Sits between the host/bench byte source and top_cpu (instruction memory write port, CPU reset).

Parameters:
- ADDR_W, 10, instruction-memory byte-address width.
- MAX_WORDS, 256, largest accepted image in words; must be at most 2^(ADDR_W-2).
- BASE_ADDR, 0, byte address of the first word; must be word-aligned.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  byte valid
- in_ready  out  1  loader can accept a byte
- restart  in  1  single-cycle pulse; starts a new load from DONE or ERR
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  byte address of the word being written
- imem_wdata  out  32  assembled word
- cpu_reset_n  out  1  0 holds the CPU in reset, 1 releases it
- done  out  1  image loaded and verified (level)
- error  out  1  frame error (level, sticky)

Behaviour:
- Reset (reset==0 at posedge clk) sets:
  - state LEN0, in_ready 1, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, cpu_reset_n 0, done 0, error 0.
  - Byte counter, word counter and running XOR all cleared.
- A byte is accepted only on a cycle where in_valid and in_ready are both 1. Bytes offered while in_valid is 0 are never sampled.
- Frame format:
  - LEN_LO, LEN_HI: 16-bit word count N.
  - N×4 data bytes, each word least-significant byte first.
  - CSUM: one byte equal to the XOR of every preceding frame byte.
- Every accepted byte except CSUM is XORed into the running checksum.
- State machine:
  - LEN0: accept LEN_LO -> LEN1.
  - LEN1: accept LEN_HI. If N > MAX_WORDS -> ERR; if N == 0 -> CSUM; otherwise -> DATA.
  - DATA: accept data bytes into a 24-bit assembly register with a 2-bit byte index. On the 4th byte of a word, the next cycle has:
    - imem_we = 1,
    - imem_wdata = {byte3, byte2, byte1, byte0},
    - imem_addr = BASE_ADDR + 4×word_index.
    - After word N-1 has been accepted -> CSUM.
  - CSUM: accept one byte. If it matches the running XOR -> DONE, else -> ERR.
  - DONE: in_ready 0, done 1, cpu_reset_n 1.
  - ERR: in_ready 0, error 1, cpu_reset_n 0.
- Write timing: imem_we is a single-cycle pulse, registered, asserted one cycle after the 4th byte is accepted.
  - in_ready stays 1 during the write cycle, so a back-to-back stream (one byte per cycle) is sustained with no stalls.
  - imem_addr and imem_wdata hold their last values while imem_we is 0.
- restart (DONE or ERR only):
  - Next state LEN0, with the same register values as reset except that imem_addr/imem_wdata hold.
  - cpu_reset_n drops to 0 in the same edge.
  - restart in any other state is ignored.
- done is asserted in the same cycle as cpu_reset_n rises. The last imem_we pulse always precedes or coincides with the CSUM acceptance edge, never follows it.
- Reset mid-frame: the partial frame is discarded. Words already written stay in memory, and the CPU remains held.
- Address arithmetic is truncated to ADDR_W; no wrap is possible when N ≤ MAX_WORDS.

Decomposition:
- Shared package prog_loader_pkg holds:
  - state encoding constants (LEN0, LEN1, DATA, CSUM, DONE, ERR; 3-bit),
  - frame field sizes (LEN_BYTES = 2, WORD_BYTES = 4).
- One natural sub-module, word_assembler: byte index, 24-bit shift register, and the registered imem_we/imem_wdata output.
- FSM, counters and checksum stay in prog_loader.

Test Plan:
- Basic load: N=2, words 0x00500093, 0x00A00113, stream 02 00 93 00 50 00 13 01 A0 00 plus correct CSUM, one byte per cycle.
  - Required: two writes, to addr 0x000 and 0x004 with those data.
  - Then done=1, cpu_reset_n=1, in_ready=0.
- Bad checksum: same frame with CSUM XOR 0xFF.
  - Required: both writes still occur.
  - Then error=1, cpu_reset_n stays 0, done=0.
- Oversize: LEN = 0x0101 with MAX_WORDS=256.
  - Required: ERR right after LEN_HI, no imem_we ever asserted.
- Empty image: frame 00 00 00.
  - Required: no writes, done=1.
- Throttled valid: basic frame with in_valid toggling 1/0 every cycle and stray in_data values during the 0 cycles.
  - Required: identical writes; stray bytes ignored.
- Reset mid-DATA after 5 bytes, then restart from DONE of a second full load.
  - Required: state returns to LEN0 with cpu_reset_n=0; the second frame loads correctly; cpu_reset_n falls on the restart edge.
